conv2d_stream_engine: RTL
=========================

// Module: conv2d_stream_engine
// PURPOSE
//  Parametrised 3x3 conv2d engine; successor to the fixed 8x8/2-filter conv stage.
//  Accepts a frame over a valid/ready pixel stream and runtime-loadable weights/bias.
//  Computes NUM_FILT filters in parallel: signed MAC, bias, arithmetic shift, optional ReLU, saturation.
//  Emits one channel per beat on a valid/ready output stream feeding the relu/maxpool/linear chain.
// PARAMETERS
//  IMG_W     8   image width in pixels (>=3)
//  IMG_H     8   image height in pixels (>=3)
//  NUM_FILT  2   number of 3x3 filters (1..8)
//  DATA_W    8   pixel/output width; weights and bias are signed 8-bit
//  ACC_W     20  signed accumulator width (>= DATA_W+8+4)
//  SHIFT     3   arithmetic right shift applied to accumulator before output
//  PAD       1   1: zero-pad, IMG_W*IMG_H outputs; 0: valid conv, (IMG_W-2)*(IMG_H-2) outputs
//  RELU_EN   1   1: unsigned out, clamp [0,2^DATA_W-1]; 0: signed out, clamp [-2^(DATA_W-1),2^(DATA_W-1)-1]
// PORTS
//  clk        in   1                     clock, all state on rising edge
//  rst_n      in   1                     synchronous reset, active low
//  pix_valid  in   1                     pixel beat valid
//  pix_ready  out  1                     engine can accept pixel (high only in S_LOAD)
//  pix_data   in   DATA_W                unsigned pixel, raster order row 0 col 0 first
//  cfg_we     in   1                     weight/bias write strobe
//  cfg_addr   in   clog2(NUM_FILT*10)    f*9+k = weight (filter f, tap k raster); NUM_FILT*9+f = bias f
//  cfg_data   in   8                     signed weight/bias value
//  out_valid  out  1                     output beat valid
//  out_ready  in   1                     downstream accepts beat
//  out_data   out  DATA_W                result for channel out_ch
//  out_ch     out  clog2(NUM_FILT)       filter index of current beat
//  out_last   out  1                     high on final beat of the frame
//  busy       out  1                     high whenever state != S_LOAD
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=S_LOAD; pixel/position/tap/channel counters=0; all weights and bias=0.
//   Outputs: pix_ready=1, out_valid=0, out_data=0, out_ch=0, out_last=0, busy=0. Pixel buffer is not cleared.
//  S_LOAD:
//   - pixel stored on pix_valid&&pix_ready; counter wraps 0..IMG_W*IMG_H-1.
//   - the last pixel's handshake moves the FSM to S_MAC at the next cycle, at position 0.
//   - cfg writes take effect only in S_LOAD; ignored in other states or when cfg_addr is out of range.
//   - same-cycle cfg write and pixel beat are both honoured.
//  S_MAC: 9 cycles, tap k=0..8.
//   - acc_f initialised to sext(bias_f)<<<SHIFT, then acc_f += $signed({1'b0,pix}) * w_f[k] for all f in parallel.
//   - out-of-image taps read 0 (PAD=1 only).
//   - on the 9th cycle, results are registered and the FSM moves to S_OUT.
//  Result transform: r = acc_f>>>SHIFT, then clamp per RELU_EN; out_data = low DATA_W bits of clamped r.
//  S_OUT:
//   - out_valid=1; beats ch=0..NUM_FILT-1, each advancing on out_valid&&out_ready.
//   - out_data/out_ch/out_last held stable while out_valid&&!out_ready.
//   - after the last channel: next position -> S_MAC, or, on the final position, -> S_LOAD (out_valid=0 next cycle).
//  Latency: first out_valid rises 10 cycles after the last pixel's handshake edge.
//   Steady state with out_ready=1: 9+NUM_FILT cycles per position.
//  pix_valid outside S_LOAD is ignored (pix_ready=0). No overflow within ACC_W given the ACC_W constraint.
//  Reset mid-frame (any state) aborts the frame immediately; weights must be reloaded.
// TESTING
//  T1 PAD=1, all w=1, b=0, pixels=8: corner=4, edge=6, interior=9; 128 beats; out_last only on the 128th.
//  T2 b0=16, all w0=0: ch0 all = 16; w1 all = -1, pixels=50: ch1 all = 0 (RELU_EN=1).
//  T3 all w=127, pixels=255: 291465>>>3=36433 -> out_data=255 (saturate); RELU_EN=0 build -> 127.
//  T4 out_ready random 30%: data stable while stalled; beat sequence ch0,ch1 per position; count exact.
//  T5 cfg write during S_MAC (addr 0, data 5): ignored; results match prior weights.
//  T6 rst_n low 1 cycle mid-S_OUT: next cycle out_valid=0, pix_ready=1, busy=0; fresh frame with zero weights -> all outputs 0.

Source files
------------

// File: rtl/conv2d_stream_engine.sv
// Streaming 3x3 conv2d engine: buffers one frame, then evaluates NUM_FILT filters in
// parallel per output position (one tap per cycle) and emits one channel per output beat.
module conv2d_stream_engine #(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int NUM_FILT = 2,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 20,
    parameter int SHIFT    = 3,
    parameter int PAD      = 1,
    parameter int RELU_EN  = 1
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             pix_valid,
    output logic                                             pix_ready,
    input  logic [DATA_W-1:0]                                pix_data,
    input  logic                                             cfg_we,
    input  logic [$clog2(NUM_FILT*10)-1:0]                   cfg_addr,
    input  logic [7:0]                                       cfg_data,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [DATA_W-1:0]                                out_data,
    output logic [((NUM_FILT > 1) ? $clog2(NUM_FILT) : 1)-1:0] out_ch,
    output logic                                             out_last,
    output logic                                             busy
);

    localparam int COEF_W = 8;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int OFF    = (PAD != 0) ? 0 : 1;
    localparam int OUT_W  = IMG_W - 2 * OFF;
    localparam int OUT_H  = IMG_H - 2 * OFF;
    localparam int PIX_AW = $clog2(NPIX);
    localparam int CFG_AW = $clog2(NUM_FILT * 10);
    localparam int CH_W   = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
    localparam int COL_W  = $clog2(IMG_W + 1);
    localparam int ROW_W  = $clog2(IMG_H + 1);
    localparam int PROD_W = DATA_W + 1 + COEF_W;

    localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'((1 << DATA_W) - 1);
    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] S_MIN = -S_MAX - 1;

    typedef enum logic [1:0] {S_LOAD, S_MAC, S_OUT} state_t;

    function automatic logic signed [ACC_W-1:0] bias_init(input logic signed [COEF_W-1:0] b);
        return ACC_W'(b) <<< SHIFT;
    endfunction

    function automatic logic [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        r = acc >>> SHIFT;
        if (RELU_EN != 0) begin
            if (r[ACC_W-1]) return '0;
            if (r > U_MAX) return '1;
        end else begin
            if (r > S_MAX) return {1'b0, {(DATA_W-1){1'b1}}};
            if (r < S_MIN) return {1'b1, {(DATA_W-1){1'b0}}};
        end
        return r[DATA_W-1:0];
    endfunction

    state_t                    state, state_n;
    logic [PIX_AW-1:0]         pix_cnt;
    logic                      load_done;
    logic [COL_W-1:0]          col_cnt;
    logic [ROW_W-1:0]          row_cnt;
    logic [3:0]                tap_cnt;
    logic [CH_W-1:0]           ch_cnt;

    logic [DATA_W-1:0]         pix_buf [NPIX];
    logic signed [COEF_W-1:0]  w_mem   [NUM_FILT][9];
    logic signed [COEF_W-1:0]  b_mem   [NUM_FILT];
    logic signed [ACC_W-1:0]   acc_p0  [NUM_FILT];
    logic signed [ACC_W-1:0]   acc_nxt [NUM_FILT];
    logic signed [PROD_W-1:0]  prod    [NUM_FILT];
    logic [DATA_W-1:0]         res_p1  [NUM_FILT];

    int                        tap_r, tap_c;
    logic                      tap_in;
    logic [PIX_AW-1:0]         rd_addr;
    logic [DATA_W-1:0]         tap_pix;

    logic pix_hs, pix_last, tap_last, ch_last, col_last, row_last, pos_last, cfg_ok;

    assign pix_hs   = pix_valid && pix_ready;
    assign pix_last = (pix_cnt == PIX_AW'(NPIX - 1));
    assign tap_last = (tap_cnt == 4'd8);
    assign ch_last  = (ch_cnt == CH_W'(NUM_FILT - 1));
    assign col_last = (col_cnt == COL_W'(OUT_W - 1));
    assign row_last = (row_cnt == ROW_W'(OUT_H - 1));
    assign pos_last = col_last && row_last;
    assign cfg_ok   = cfg_we && (state == S_LOAD);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_LOAD;
        else        state <= state_n;
    end

    // load_done holds off S_MAC for one cycle after the last pixel and blocks further beats
    always_comb begin
        state_n = state;
        unique case (state)
            S_LOAD:  if (load_done) state_n = S_MAC;
            S_MAC:   if (tap_last) state_n = S_OUT;
            S_OUT:   if (out_ready && ch_last) state_n = pos_last ? S_LOAD : S_MAC;
            default: state_n = S_LOAD;
        endcase
    end

    // Stage p0: tap fetch from the frame buffer and parallel multiply-accumulate
    always_comb begin
        tap_r   = int'(row_cnt) + OFF + int'(tap_cnt) / 3 - 1;
        tap_c   = int'(col_cnt) + OFF + int'(tap_cnt) % 3 - 1;
        tap_in  = (tap_r >= 0) && (tap_r < IMG_H) && (tap_c >= 0) && (tap_c < IMG_W);
        rd_addr = PIX_AW'(tap_r * IMG_W + tap_c);
        tap_pix = tap_in ? pix_buf[rd_addr] : '0;
        for (int f = 0; f < NUM_FILT; f++) begin
            prod[f]    = $signed({1'b0, tap_pix}) * w_mem[f][tap_cnt];
            acc_nxt[f] = ((tap_cnt == 4'd0) ? bias_init(b_mem[f]) : acc_p0[f]) + ACC_W'(prod[f]);
        end
    end

    always_ff @(posedge clk) begin
        if (pix_hs) pix_buf[pix_cnt] <= pix_data;
        if (state == S_MAC) begin
            for (int f = 0; f < NUM_FILT; f++) acc_p0[f] <= acc_nxt[f];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt   <= '0;
            load_done <= 1'b0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            tap_cnt   <= '0;
            ch_cnt    <= '0;
            for (int f = 0; f < NUM_FILT; f++) begin
                b_mem[f]  <= '0;
                res_p1[f] <= '0;
                for (int k = 0; k < 9; k++) w_mem[f][k] <= '0;
            end
        end else begin
            load_done <= pix_hs && pix_last;
            if (pix_hs) pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
            for (int f = 0; f < NUM_FILT; f++) begin
                for (int k = 0; k < 9; k++) begin
                    if (cfg_ok && cfg_addr == CFG_AW'(f * 9 + k)) w_mem[f][k] <= cfg_data;
                end
                if (cfg_ok && cfg_addr == CFG_AW'(NUM_FILT * 9 + f)) b_mem[f] <= cfg_data;
            end
            // Stage p1: final tap result transformed and registered for the output beats
            if (state == S_MAC) begin
                tap_cnt <= tap_last ? 4'd0 : tap_cnt + 4'd1;
                if (tap_last) begin
                    for (int f = 0; f < NUM_FILT; f++) res_p1[f] <= sat_out(acc_nxt[f]);
                end
            end
            if (state == S_OUT && out_ready) begin
                ch_cnt <= ch_last ? '0 : ch_cnt + 1'b1;
                if (ch_last) begin
                    if (col_last) begin
                        col_cnt <= '0;
                        row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign pix_ready = (state == S_LOAD) && !load_done;
    assign out_valid = (state == S_OUT);
    assign out_data  = res_p1[ch_cnt];
    assign out_ch    = ch_cnt;
    assign out_last  = out_valid && pos_last && ch_last;
    assign busy      = (state != S_LOAD);

endmodule
